// File: rtl/opcode_tag_allocator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : opcode_tag_allocator_pkg
// Description : Shared types and constants for the opcode-tag space.
//               An opcode tag is {opcode type, per-type index}, so each type
//               owns a contiguous block starting at type << TAG_BITS.
// Contents    : opcodeEnumT, opcodeTagT, tagIndexT, tagAllocDrainStateT,
//               OPCODEABASE_* block bases, opcode_tag_base() helper.
// Revision    : 1.0 - initial release
// ============================================================================
package opcode_tag_allocator_pkg;

  localparam int NUM_TYPES_DEF = 5;
  localparam int TAG_BITS_DEF  = 6;
  localparam int TYPE_W_DEF    = (NUM_TYPES_DEF > 1) ? $clog2(NUM_TYPES_DEF) : 1;
  localparam int TAG_W_DEF     = TYPE_W_DEF + TAG_BITS_DEF;

  typedef enum logic [TYPE_W_DEF-1:0] {
    OP_READ  = 3'd0,
    OP_WRITE = 3'd1,
    OP_WAIT  = 3'd2,
    OP_EVICT = 3'd3,
    OP_TRIM  = 3'd4
  } opcodeEnumT;

  typedef logic [TAG_W_DEF-1:0]    opcodeTagT;
  typedef logic [TAG_BITS_DEF-1:0] tagIndexT;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } tagAllocDrainStateT;

  // First tag of a type's block.
  function automatic opcodeTagT opcode_tag_base(input opcodeEnumT op);
    return {op, tagIndexT'(0)};
  endfunction

  localparam opcodeTagT OPCODEABASE_READ  = opcode_tag_base(OP_READ);
  localparam opcodeTagT OPCODEABASE_WRITE = opcode_tag_base(OP_WRITE);
  localparam opcodeTagT OPCODEABASE_WAIT  = opcode_tag_base(OP_WAIT);
  localparam opcodeTagT OPCODEABASE_EVICT = opcode_tag_base(OP_EVICT);
  localparam opcodeTagT OPCODEABASE_TRIM  = opcode_tag_base(OP_TRIM);

endpackage
`default_nettype wire

// File: rtl/tag_pool_lsb_find.sv
`default_nettype none
// ============================================================================
// Module      : tag_pool_lsb_find
// Description : Lowest-zero priority encoder over a tag-pool bitmap.
// Ports       : bits_i  - bitmap, 1 = tag in use
//               idx_o   - index of the lowest clear bit (0 when none)
//               empty_o - no clear bit exists (pool exhausted)
// Revision    : 1.0 - initial release
// ============================================================================
module tag_pool_lsb_find #(
  parameter int WIDTH = 64,
  parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] bits_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             empty_o
);

  // Scan downwards so the last hit written is the lowest clear bit.
  always_comb begin
    idx_o   = '0;
    empty_o = 1'b1;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!bits_i[i]) begin
        idx_o   = IDX_W'(i);
        empty_o = 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/opcode_tag_allocator.sv
`default_nettype none
// ============================================================================
// Module      : opcode_tag_allocator
// Description : Per-opcode-type tag allocator. Grants the lowest free index
//               of the requested type, accepts releases, tracks outstanding
//               tags, flags protocol errors and supports a drain/quiesce mode.
// Ports       : clk, rst_n (sync, active low)
//               alloc_valid/alloc_type/alloc_ready/alloc_tag - zero-latency
//                 allocation handshake, one grant per cycle
//               rel_valid/rel_tag - release strobe, always accepted
//               drain_req/drain_done - quiesce request / pool empty+blocked
//               outstanding_total - registered count of allocated tags
//               err_double_free/err_bad_type - sticky errors, err_clr clears
// Revision    : 1.0 - initial release
// ============================================================================
module opcode_tag_allocator
  import opcode_tag_allocator_pkg::*;
#(
  parameter int NUM_TYPES = 5,
  parameter int TAG_BITS  = 6,
  parameter int MAX_OUT   = 64,
  parameter int TYPE_W    = (NUM_TYPES > 1) ? $clog2(NUM_TYPES) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       alloc_valid,
  input  logic [TYPE_W-1:0]          alloc_type,
  output logic                       alloc_ready,
  output logic [TYPE_W+TAG_BITS-1:0] alloc_tag,
  input  logic                       rel_valid,
  input  logic [TYPE_W+TAG_BITS-1:0] rel_tag,
  input  logic                       drain_req,
  output logic                       drain_done,
  output logic [TYPE_W+TAG_BITS:0]   outstanding_total,
  output logic                       err_double_free,
  output logic                       err_bad_type,
  input  logic                       err_clr
);

  localparam int c_pool  = 2 ** TAG_BITS;
  localparam int c_tot_w = TYPE_W + TAG_BITS + 1;

  localparam logic [TYPE_W:0]   c_num_types = (TYPE_W + 1)'(NUM_TYPES);
  localparam logic [TAG_BITS:0] c_max_out   = (TAG_BITS + 1)'(MAX_OUT);
  localparam logic [TAG_BITS:0] c_cnt_one   = (TAG_BITS + 1)'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [c_pool-1:0]   used_q  [NUM_TYPES];
  logic [c_pool-1:0]   used_d  [NUM_TYPES];
  logic [TAG_BITS:0]   count_q [NUM_TYPES];
  logic [TAG_BITS:0]   count_d [NUM_TYPES];
  logic [c_tot_w-1:0]  total_q, total_d;
  logic                err_df_q, err_df_d;
  logic                err_bt_q, err_bt_d;
  tagAllocDrainStateT  state_q, state_d;

  // --------------------------------------------------------------------------
  // Allocation side: type-selected bitmap feeds the single encoder
  // --------------------------------------------------------------------------
  logic                alloc_type_ok;
  logic [TYPE_W-1:0]   alloc_sel;
  logic [c_pool-1:0]   alloc_bits;
  logic [TAG_BITS-1:0] free_idx;
  logic                pool_full;
  logic                cap_ok;
  logic                alloc_fire;

  assign alloc_type_ok = ({1'b0, alloc_type} < c_num_types);
  // Out-of-range types are steered to type 0 so no array read goes off the end.
  assign alloc_sel     = alloc_type_ok ? alloc_type : '0;
  assign alloc_bits    = used_q[alloc_sel];

  tag_pool_lsb_find #(
    .WIDTH (c_pool),
    .IDX_W (TAG_BITS)
  ) u_lsb_find (
    .bits_i  (alloc_bits),
    .idx_o   (free_idx),
    .empty_o (pool_full)
  );

  assign cap_ok     = (count_q[alloc_sel] < c_max_out) && !pool_full;
  assign alloc_tag  = (alloc_type_ok && !pool_full) ? {alloc_type, free_idx} : '0;
  // A bad type is handshaken but never makes an allocation.
  assign alloc_fire = alloc_valid && alloc_ready && alloc_type_ok;

  // --------------------------------------------------------------------------
  // Release side
  // --------------------------------------------------------------------------
  logic [TYPE_W-1:0]   rel_type;
  logic [TAG_BITS-1:0] rel_idx;
  logic                rel_type_ok;
  logic [TYPE_W-1:0]   rel_sel;
  logic                rel_hit;
  logic                rel_fire;

  assign rel_type    = rel_tag[TYPE_W+TAG_BITS-1:TAG_BITS];
  assign rel_idx     = rel_tag[TAG_BITS-1:0];
  assign rel_type_ok = ({1'b0, rel_type} < c_num_types);
  assign rel_sel     = rel_type_ok ? rel_type : '0;
  assign rel_hit     = used_q[rel_sel][rel_idx];
  assign rel_fire    = rel_valid && rel_type_ok && rel_hit;

  // --------------------------------------------------------------------------
  // Bitmap / count / total next state. The encoder only ever sees used_q, so
  // a tag released this cycle cannot be re-granted until the next one. When
  // both hit the same type, the +1 and -1 cancel on the count.
  // --------------------------------------------------------------------------
  always_comb begin
    for (int t = 0; t < NUM_TYPES; t++) begin
      used_d[t]  = used_q[t];
      count_d[t] = count_q[t];
    end
    if (alloc_fire) begin
      used_d[alloc_sel][free_idx] = 1'b1;
      count_d[alloc_sel]          = count_d[alloc_sel] + c_cnt_one;
    end
    if (rel_fire) begin
      used_d[rel_sel][rel_idx] = 1'b0;
      count_d[rel_sel]         = count_d[rel_sel] - c_cnt_one;
    end
    total_d = '0;
    for (int t = 0; t < NUM_TYPES; t++) begin
      total_d = total_d + c_tot_w'(count_d[t]);
    end
  end

  // Sticky errors: a new error in the same cycle as err_clr wins.
  always_comb begin
    err_df_d = err_clr ? 1'b0 : err_df_q;
    err_bt_d = err_clr ? 1'b0 : err_bt_q;
    if (rel_valid && rel_type_ok && !rel_hit) begin
      err_df_d = 1'b1;
    end
    if ((alloc_valid && alloc_ready && !alloc_type_ok) || (rel_valid && !rel_type_ok)) begin
      err_bt_d = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Drain FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    alloc_ready = 1'b0;
    drain_done  = 1'b0;
    unique case (state_q)
      IDLE: begin
        alloc_ready = rst_n && (alloc_type_ok ? cap_ok : 1'b1);
        if (drain_req) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!drain_req) begin
          state_d = IDLE;
        end else if (total_q == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        drain_done = 1'b1;
        if (!drain_req) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int t = 0; t < NUM_TYPES; t++) begin
        used_q[t]  <= '0;
        count_q[t] <= '0;
      end
      total_q  <= '0;
      err_df_q <= 1'b0;
      err_bt_q <= 1'b0;
      state_q  <= IDLE;
    end else begin
      for (int t = 0; t < NUM_TYPES; t++) begin
        used_q[t]  <= used_d[t];
        count_q[t] <= count_d[t];
      end
      total_q  <= total_d;
      err_df_q <= err_df_d;
      err_bt_q <= err_bt_d;
      state_q  <= state_d;
    end
  end

  assign outstanding_total = total_q;
  assign err_double_free   = err_df_q;
  assign err_bad_type      = err_bt_q;

endmodule
`default_nettype wire

// File: doc/opcode_tag_allocator.md
Name: opcode_tag_allocator

Overview:
- Parametrised tag allocator for the opcode-tag space: opcodeTag = {opcode type, per-type index}, so type base = type << TAG_BITS (0x000 READ, 0x040 WRITE, 0x080 WAIT, 0x0C0 EVICT, 0x100 TRIM at defaults).
- Hands out the lowest free index per type, accepts releases, tracks outstanding counts, flags protocol errors, and provides a drain mode that quiesces the pool.
- Sits between the command issuer and completion path; it replaces fixed hand-assigned tags.

Parameters:
- NUM_TYPES, 5, number of opcode types; matches opcodeEnumT.
- TAG_BITS, 6, index bits per type; 2**TAG_BITS tags per type.
- MAX_OUT, 64, per-type outstanding limit, 1..2**TAG_BITS.
- TYPE_W, max(1,$clog2(NUM_TYPES)), derived: type field width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- alloc_valid  in  1  allocation request
- alloc_type  in  TYPE_W  requested opcode type (opcodeEnumT)
- alloc_ready  out  1  request accepted this cycle
- alloc_tag  out  TYPE_W+TAG_BITS  allocated tag; valid when alloc_valid&&alloc_ready
- rel_valid  in  1  release strobe (no backpressure)
- rel_tag  in  TYPE_W+TAG_BITS  tag being released
- drain_req  in  1  level; request quiesce
- drain_done  out  1  level; pool empty and allocation blocked
- outstanding_total  out  TYPE_W+TAG_BITS+1  sum of allocated tags, registered
- err_double_free  out  1  sticky; release of an unallocated tag
- err_bad_type  out  1  sticky; type >= NUM_TYPES on alloc or release
- err_clr  in  1  clears both sticky errors

Behaviour:
- Reset (rst_n low at a clk edge): all tags free, per-type counts 0, FSM IDLE. Outputs: alloc_ready 0 during reset, drain_done 0, outstanding_total 0, errors 0. Reset mid-operation discards all allocations.
- State: per-type used bitmap [NUM_TYPES][2**TAG_BITS], per-type count [TAG_BITS+1 bits].
- alloc_tag is combinational: {alloc_type, lowest clear bit of used[alloc_type]}. Zero when the type is bad or the pool is empty.
- alloc_ready = (state==IDLE) && (type valid ? (count<MAX_OUT && pool not full) : 1).
- A bad type is accepted and dropped: no allocation is made, err_bad_type is set next cycle, and alloc_tag is 0.
- Accept updates the bitmap and count at the next edge. Zero-latency handshake, one grant per cycle.
- Release: if the type is valid and the bit is set, clear the bit and decrement the count next cycle. If the bit is clear, set err_double_free and leave state unchanged. If the type is bad, set err_bad_type and ignore the release.
- Release and allocation in the same cycle:
  - Allocation sees the pre-release bitmap, so there is no bypass. A tag released in cycle N becomes allocatable in N+1.
  - Same-type count net change is 0.
- err_clr and a new error in the same cycle: the error wins (set has priority).
- outstanding_total is registered and reflects accepted transactions one cycle later.
- Drain FSM:
  - IDLE: drain_req -> DRAIN.
  - DRAIN: alloc_ready=0. drain_req low -> IDLE (abort). outstanding_total==0 -> DONE.
  - DONE: drain_done=1 and alloc_ready=0. drain_req low -> IDLE.
  - Releases are processed in every state.
- MAX_OUT < 2**TAG_BITS caps the count; only indices 0..MAX_OUT-1 are ever reachable in steady use.

Decomposition:
- Shared package (mixed_package or successor):
  - opcodeEnumT and opcodeTagT (TYPE_W+TAG_BITS wide).
  - OPCODEABASE_* constants, generated as type << TAG_BITS.
  - New tagIndexT typedef and a tagAllocDrainStateT enum {IDLE, DRAIN, DONE}.
- One sub-module: tag_pool_lsb_find, a parametrised lowest-zero priority encoder over 2**TAG_BITS bits with an empty flag. It is instantiated once, fed through a type-selected bitmap mux.

Test Plan:
- After reset, alloc type 1 twice -> tags 0x040, 0x041. Release 0x040, then alloc type 1 -> 0x040. outstanding_total 2.
- Alloc type 2 sixty-four times -> 0x080..0x0BF. 65th request sees alloc_ready=0. Release 0x0A3 -> next cycle alloc returns 0x0A3.
- In one cycle, release 0x100 and alloc type 4 with only 0x100 used -> granted 0x101, not 0x100. Next alloc -> 0x100. Count stays 1 over that cycle.
- Release unallocated 0x0C5 -> err_double_free=1, counts unchanged. Alloc type 7 -> accepted, err_bad_type=1. err_clr -> both 0.
- With 3 tags outstanding, assert drain_req -> alloc_ready=0. Release the 3 tags -> drain_done=1 one cycle after outstanding_total=0. Drop drain_req -> IDLE and alloc_ready=1.
- With 10 tags outstanding in DRAIN, pulse rst_n low for one cycle -> all outputs at reset values, FSM IDLE, next alloc type 0 -> 0x000.
